mips_cpu_mem_master: RTL and testbench
======================================

// Module: mips_cpu_mem_master
// PURPOSE
// Bus initiator between the CPU load/store unit and the 32-bit word memory slave (read/write/waitrequest/byteenable).
// Accepts one byte/half/word access at a time and drives a single bus transaction.
// Honours waitrequest and captures readdata a fixed number of cycles after acceptance.
// Returns lane-extracted, sign/zero-extended load data, or an error for misaligned or timed-out accesses.
// PARAMETERS
// READ_LATENCY    1  cycles from read accept (read=1, waitrequest=0) to valid readdata; legal 1..4
// TIMEOUT_CYCLES  0  max consecutive waitrequest cycles before abort with error; 0 = never time out
// PORTS
// clk          input   1   rising-edge clock
// reset        input   1   synchronous, active-high reset
// req_valid    input   1   CPU access request
// req_ready    output  1   block idle and able to accept; handshake = req_valid & req_ready
// req_write    input   1   1 = store, 0 = load
// req_size     input   2   00 byte, 01 half, 10 word; 11 is treated as word
// req_signed   input   1   loads only: 1 = sign-extend, 0 = zero-extend
// req_addr     input   32  byte address
// req_wdata    input   32  store data, right-justified
// resp_valid   output  1   one-cycle completion pulse
// resp_rdata   output  32  load result, valid with resp_valid; 0 for stores and errors
// resp_err     output  1   valid with resp_valid: misaligned access or timeout
// address      output  32  bus byte address, req_addr with [1:0] forced to 00
// write        output  1   bus write strobe
// read         output  1   bus read strobe
// waitrequest  input   1   slave stall; strobes and bus fields held while high
// writedata    output  32  store data replicated across lanes
// byteenable   output  4   active lanes; lane k = bits [8k+7:8k] = byte address offset k
// readdata     input   32  slave read data
// BEHAVIOUR
// Reset: state=IDLE; req_ready=1; resp_valid=0, resp_err=0, resp_rdata=0; read=write=0; address=0, writedata=0, byteenable=0.
// Reset mid-transaction drops strobes at the next edge. Any pending response is discarded.
// All request fields are latched on the handshake. The request inputs are ignored afterwards.
// Byteenable: word 1111; half addr[1]=0 -> 0011, =1 -> 1100; byte -> 0001 << addr[1:0].
// Writedata: word as-is; half {2{wdata[15:0]}}; byte {4{wdata[7:0]}}.
// Misaligned accesses (half with addr[0]=1, word with addr[1:0]!=0):
//   - no bus strobe is issued
//   - FSM goes IDLE->ERR; the ERR cycle drives resp_valid=1, resp_err=1, resp_rdata=0
//   - FSM returns to IDLE
// FSM states: IDLE, BUS, RDWAIT, RESP, ERR.
//  IDLE: req_ready=1; on handshake go to BUS (aligned) or ERR (misaligned).
//  BUS: read or write asserted with stable address, byteenable and writedata.
//   - While waitrequest=1: stay in BUS and increment the stall counter.
//   - If TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES: drop the strobe and go to ERR.
//   - When waitrequest=0 (accept): write goes to RESP; read loads the latency counter with READ_LATENCY and goes to RDWAIT.
//   - The strobe is deasserted the cycle after accept.
//  RDWAIT: decrement the counter each cycle.
//   - On the cycle the count reaches 0, sample readdata and go to RESP.
//   - With READ_LATENCY=1, readdata is sampled at the first RDWAIT edge.
//  RESP: resp_valid=1 for exactly one cycle, then IDLE (req_ready=1).
// Load extraction: byte = readdata lane addr[1:0]; half = lanes {addr[1]*2+1, addr[1]*2}.
// Load extension: sign-extend on req_signed=1, zero-extend otherwise; word = readdata unchanged.
// Aligned write timing: handshake edge 0 -> write=1 in cycle 1 -> accept with no stall -> resp_valid in cycle 2.
// Read timing: no-stall read with READ_LATENCY=1 gives resp_valid in cycle 3.
// Back-to-back accesses: the earliest next handshake is the cycle after resp_valid.
// req_ready=0 in every state except IDLE.
// TESTING
// Word store addr 0xBFC00010, data 0xDEADBEEF, no stall -> address=0xBFC00010, byteenable=1111, write 1 cycle, resp_valid 1 cycle later, resp_err=0.
// Byte store addr 0xBFC00013, data 0x000000AB -> byteenable=1000, writedata=0xABABABAB.
// Signed byte load addr 0xBFC00011, readdata=0x1234F056 -> resp_rdata=0xFFFFFFF0; unsigned -> 0x000000F0.
// Half load addr 0xBFC00002, readdata=0x8001FFFF, waitrequest high 3 cycles -> read held 4 cycles with stable address, resp_rdata=0xFFFF8001 (signed).
// Word load addr 0xBFC00006 -> no read strobe, resp_valid with resp_err=1, resp_rdata=0.
// TIMEOUT_CYCLES=8, waitrequest stuck high -> read drops after 8 stall cycles, resp_err=1; reset asserted during BUS -> read=0 and req_ready=1 after the edge.

Source files
------------

// File: rtl/mips_cpu_mem_master_if.sv
// Bundles the CPU request/response handshake and the word-memory bus of the
// load/store bus initiator.
interface mips_cpu_mem_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] address;
  logic        write;
  logic        read;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;

  modport master (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  waitrequest, readdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output address, write, read, writedata, byteenable
  );

  modport slave (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output waitrequest, readdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  address, write, read, writedata, byteenable
  );
endinterface

// File: rtl/mips_cpu_mem_master.sv
// Single-outstanding bus initiator: turns one byte/half/word CPU access into one
// memory transaction and returns extended load data or an error.
module mips_cpu_mem_master #(
  parameter int READ_LATENCY   = 1,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  mips_cpu_mem_master_if.master bus
);

  typedef enum logic [2:0] {IDLE, BUS, RDWAIT, RESP, ERR} state_t;

  localparam int SW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [SW-1:0] STALL_LAST = SW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [2:0]    LAT_INIT   = 3'(READ_LATENCY);

  state_t        state_reg, state_next;
  logic          write_reg;
  logic [1:0]    size_reg;
  logic          signed_reg;
  logic [1:0]    addr_lo_reg;
  logic [31:0]   address_reg;
  logic [31:0]   wdata_reg;
  logic [3:0]    be_reg;
  logic [SW-1:0] stall_cnt_reg;
  logic [2:0]    lat_cnt_reg;
  logic [31:0]   rdata_reg;

  logic [3:0]  be_in;
  logic [31:0] wdata_in;
  logic        misaligned;
  logic        timeout_hit;
  logic        lat_done;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_val;

  // Per-lane enable and store-data replication; size 11 behaves as word.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign be_in[gi] = bus.req_size[1] ? 1'b1 :
                         bus.req_size[0] ? (bus.req_addr[1] == LANE[1]) :
                                           (bus.req_addr[1:0] == LANE);
      assign wdata_in[8*gi +: 8] = bus.req_size[1] ? bus.req_wdata[8*gi +: 8] :
                                   bus.req_size[0] ? bus.req_wdata[8*(gi%2) +: 8] :
                                                     bus.req_wdata[7:0];
    end
  endgenerate

  assign misaligned  = (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                       (bus.req_size[1] && bus.req_addr[1:0] != 2'b00);
  assign timeout_hit = (TIMEOUT_CYCLES > 0) && bus.waitrequest && (stall_cnt_reg == STALL_LAST);
  assign lat_done    = (lat_cnt_reg == 3'd1);

  always_comb begin
    rd_byte  = bus.readdata[{addr_lo_reg, 3'b000} +: 8];
    rd_half  = addr_lo_reg[1] ? bus.readdata[31:16] : bus.readdata[15:0];
    case (size_reg)
      2'b00:   load_val = signed_reg ? {{24{rd_byte[7]}}, rd_byte} : {24'b0, rd_byte};
      2'b01:   load_val = signed_reg ? {{16{rd_half[15]}}, rd_half} : {16'b0, rd_half};
      default: load_val = bus.readdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.req_valid) state_next = misaligned ? ERR : BUS;
      BUS: begin
        if (!bus.waitrequest) state_next = write_reg ? RESP : RDWAIT;
        else if (timeout_hit) state_next = ERR;
      end
      RDWAIT:  if (lat_done) state_next = RESP;
      RESP:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state_reg == IDLE);
    bus.read       = (state_reg == BUS) && !write_reg;
    bus.write      = (state_reg == BUS) && write_reg;
    bus.resp_valid = (state_reg == RESP) || (state_reg == ERR);
    bus.resp_err   = (state_reg == ERR);
    bus.resp_rdata = (state_reg == RESP) ? rdata_reg : 32'h0;
    bus.address    = address_reg;
    bus.writedata  = wdata_reg;
    bus.byteenable = be_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      write_reg     <= 1'b0;
      size_reg      <= 2'b00;
      signed_reg    <= 1'b0;
      addr_lo_reg   <= 2'b00;
      address_reg   <= 32'h0;
      wdata_reg     <= 32'h0;
      be_reg        <= 4'h0;
      stall_cnt_reg <= '0;
      lat_cnt_reg   <= 3'd0;
      rdata_reg     <= 32'h0;
    end else begin
      case (state_reg)
        IDLE: if (bus.req_valid) begin
          write_reg     <= bus.req_write;
          size_reg      <= bus.req_size;
          signed_reg    <= bus.req_signed;
          addr_lo_reg   <= bus.req_addr[1:0];
          address_reg   <= {bus.req_addr[31:2], 2'b00};
          wdata_reg     <= wdata_in;
          be_reg        <= be_in;
          stall_cnt_reg <= '0;
          rdata_reg     <= 32'h0;
        end
        BUS: begin
          if (!bus.waitrequest) lat_cnt_reg   <= LAT_INIT;
          else                  stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
        RDWAIT: begin
          lat_cnt_reg <= lat_cnt_reg - 1'b1;
          if (lat_done) rdata_reg <= load_val;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_mem_master.sv
// Two initiators (default timing, and longer latency with timeout) driven by the
// same directed accesses, each checked every cycle against a timeline model.
module tb_mips_cpu_mem_master;

  localparam int LAT_A = 1, TO_A = 0;
  localparam int LAT_B = 3, TO_B = 8;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          stall;
    logic [31:0] lit_rdata;
    logic        lit_err;
    logic [3:0]  lit_be;
    logic [31:0] lit_wdata;
  } txn_t;

  typedef struct {
    logic        ready, rd, wr, rv, re;
    logic [31:0] rdat, addr, wd;
    logic [3:0]  be;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_cpu_mem_master_if if_a ();
  mips_cpu_mem_master_if if_b ();

  mips_cpu_mem_master #(.READ_LATENCY(LAT_A), .TIMEOUT_CYCLES(TO_A)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a));
  mips_cpu_mem_master #(.READ_LATENCY(LAT_B), .TIMEOUT_CYCLES(TO_B)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b));

  int   n_checks = 0;
  int   n_err    = 0;
  logic chk_en   = 1'b0;
  exp_t exp_a, exp_b;

  logic        seen_resp, seen_err;
  logic [31:0] seen_rdata, seen_wdata;
  logic [3:0]  seen_be;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- model ----------------
  function automatic logic misaligned(input txn_t t);
    return (t.size == 2'b01 && t.addr[0]) || (t.size[1] && t.addr[1:0] != 2'b00);
  endfunction

  function automatic logic [3:0] be_of(input txn_t t);
    if (t.size[1])      return 4'hF;
    else if (t.size[0]) return t.addr[1] ? 4'hC : 4'h3;
    else                return 4'h1 << t.addr[1:0];
  endfunction

  function automatic logic [31:0] wd_of(input txn_t t);
    if (t.size[1])      return t.wdata;
    else if (t.size[0]) return {2{t.wdata[15:0]}};
    else                return {4{t.wdata[7:0]}};
  endfunction

  function automatic logic [31:0] load_of(input txn_t t);
    logic [31:0] sh;
    int unsigned off;
    off = t.addr[1:0];
    sh  = t.rdata >> (8 * off);
    if (t.size == 2'b00) return t.sgn ? 32'(signed'(sh[7:0])) : {24'h0, sh[7:0]};
    if (t.size == 2'b01) begin
      sh = t.rdata >> (16 * int'(t.addr[1]));
      return t.sgn ? 32'(signed'(sh[15:0])) : {16'h0, sh[15:0]};
    end
    return t.rdata;
  endfunction

  function automatic bit times_out(input txn_t t, input int to);
    return !misaligned(t) && to > 0 && t.stall >= to;
  endfunction

  function automatic int model_len(input txn_t t, input int lat, input int to);
    if (misaligned(t))    return 1;
    if (times_out(t, to)) return to + 1;
    if (t.wr)             return t.stall + 2;
    return t.stall + 2 + lat;
  endfunction

  // Expected outputs k cycles after the handshake cycle (k=0 is the handshake cycle).
  function automatic exp_t model_cycle(input txn_t t, input int k, input int lat, input int to);
    exp_t e;
    int   last_strobe;
    e.ready = 1'b1; e.rd = 1'b0; e.wr = 1'b0; e.rv = 1'b0; e.re = 1'b0;
    e.rdat = 32'h0; e.addr = {t.addr[31:2], 2'b00}; e.wd = wd_of(t); e.be = be_of(t);
    if (k == 0 || k > model_len(t, lat, to)) return e;
    e.ready = 1'b0;
    last_strobe = times_out(t, to) ? to : t.stall + 1;
    if (misaligned(t) || (times_out(t, to) && k == to + 1)) begin
      e.rv = 1'b1; e.re = 1'b1;
    end else if (k <= last_strobe) begin
      e.rd = !t.wr; e.wr = t.wr;
    end else if (k == model_len(t, lat, to)) begin
      e.rv = 1'b1;
      e.rdat = t.wr ? 32'h0 : load_of(t);
    end
    return e;
  endfunction

  // ---------------- compare process ----------------
  task automatic cmp_outputs(input string tag, input exp_t got, input exp_t want);
    check({tag, ".req_ready"},  32'(got.ready), 32'(want.ready));
    check({tag, ".read"},       32'(got.rd),    32'(want.rd));
    check({tag, ".write"},      32'(got.wr),    32'(want.wr));
    check({tag, ".resp_valid"}, 32'(got.rv),    32'(want.rv));
    check({tag, ".resp_err"},   32'(got.re),    32'(want.re));
    check({tag, ".resp_rdata"}, got.rdat,       want.rdat);
    if (want.rd || want.wr) begin
      check({tag, ".address"},    got.addr,     want.addr);
      check({tag, ".byteenable"}, 32'(got.be),  32'(want.be));
      if (want.wr) check({tag, ".writedata"}, got.wd, want.wd);
    end
  endtask

  always @(negedge clk) begin
    exp_t ga, gb;
    if (chk_en) begin
      ga.ready = if_a.req_ready; ga.rd = if_a.read; ga.wr = if_a.write;
      ga.rv = if_a.resp_valid; ga.re = if_a.resp_err; ga.rdat = if_a.resp_rdata;
      ga.addr = if_a.address; ga.wd = if_a.writedata; ga.be = if_a.byteenable;
      gb.ready = if_b.req_ready; gb.rd = if_b.read; gb.wr = if_b.write;
      gb.rv = if_b.resp_valid; gb.re = if_b.resp_err; gb.rdat = if_b.resp_rdata;
      gb.addr = if_b.address; gb.wd = if_b.writedata; gb.be = if_b.byteenable;
      cmp_outputs("a", ga, exp_a);
      cmp_outputs("b", gb, exp_b);
      if (if_a.resp_valid) begin
        seen_resp = 1'b1; seen_err = if_a.resp_err; seen_rdata = if_a.resp_rdata;
      end
      if (if_a.read || if_a.write) begin
        seen_be = if_a.byteenable; seen_wdata = if_a.writedata;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive_req(input logic v, input txn_t t);
    if_a.req_valid = v;           if_b.req_valid = v;
    if_a.req_write = t.wr;        if_b.req_write = t.wr;
    if_a.req_size  = t.size;      if_b.req_size  = t.size;
    if_a.req_signed = t.sgn;      if_b.req_signed = t.sgn;
    if_a.req_addr  = t.addr;      if_b.req_addr  = t.addr;
    if_a.req_wdata = t.wdata;     if_b.req_wdata = t.wdata;
  endtask

  // Runs cycles 0..n of a transaction (or only 0..stop_k-1 when stop_k >= 0).
  task automatic run_txn(input int idx, input txn_t t, input int stop_k);
    int   n;
    txn_t junk;
    seen_resp = 1'b0; seen_err = 1'b0; seen_rdata = 32'h0; seen_be = 4'h0; seen_wdata = 32'h0;
    n = model_len(t, LAT_A, TO_A);
    if (model_len(t, LAT_B, TO_B) > n) n = model_len(t, LAT_B, TO_B);
    if (stop_k >= 0) n = stop_k - 1;
    chk_en = 1'b1;
    for (int k = 0; k <= n; k++) begin
      if (k == 0) drive_req(1'b1, t);
      else begin
        junk = t;
        junk.wr = 1'($urandom); junk.size = 2'($urandom); junk.sgn = 1'($urandom);
        junk.addr = $urandom; junk.wdata = $urandom;
        drive_req(1'b0, junk);
      end
      if_a.waitrequest = (k >= 1 && k <= t.stall);
      if_b.waitrequest = (k >= 1 && k <= t.stall);
      if_a.readdata = (k == t.stall + 1 + LAT_A) ? t.rdata : (32'h5A5A5A5A ^ 32'(k));
      if_b.readdata = (k == t.stall + 1 + LAT_B) ? t.rdata : (32'h5A5A5A5A ^ 32'(k));
      exp_a = model_cycle(t, k, LAT_A, TO_A);
      exp_b = model_cycle(t, k, LAT_B, TO_B);
      @(posedge clk);
      #1;
    end
    chk_en = 1'b0;
    if (stop_k < 0) begin
      check($sformatf("t%0d.lit_resp_seen", idx), 32'(seen_resp), 32'd1);
      check($sformatf("t%0d.lit_rdata", idx), seen_rdata, t.lit_rdata);
      check($sformatf("t%0d.lit_err", idx), 32'(seen_err), 32'(t.lit_err));
      if (!t.lit_err) check($sformatf("t%0d.lit_be", idx), 32'(seen_be), 32'(t.lit_be));
      if (!t.lit_err && t.wr) check($sformatf("t%0d.lit_wdata", idx), seen_wdata, t.lit_wdata);
      $display("txn %0d: wr=%0b size=%0d addr=%h stall=%0d -> rdata=%h err=%0b",
               idx, t.wr, t.size, t.addr, t.stall, seen_rdata, seen_err);
    end
  endtask

  function automatic txn_t mk(input logic wr, input logic [1:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int stall,
                              input logic [31:0] lit_rdata, input logic lit_err,
                              input logic [3:0] lit_be, input logic [31:0] lit_wdata);
    txn_t t;
    t.wr = wr; t.size = size; t.sgn = sgn; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
    t.stall = stall; t.lit_rdata = lit_rdata; t.lit_err = lit_err; t.lit_be = lit_be;
    t.lit_wdata = lit_wdata;
    return t;
  endfunction

  txn_t tbl[16];

  initial begin
    tbl[0]  = mk(1, 2'b10, 0, 32'hBFC00010, 32'hDEADBEEF, 32'h0,        0,  32'h0,        0, 4'hF, 32'hDEADBEEF);
    tbl[1]  = mk(1, 2'b00, 0, 32'hBFC00013, 32'h000000AB, 32'h0,        0,  32'h0,        0, 4'h8, 32'hABABABAB);
    tbl[2]  = mk(0, 2'b00, 1, 32'hBFC00011, 32'h0,        32'h1234F056, 0,  32'hFFFFFFF0, 0, 4'h2, 32'h0);
    tbl[3]  = mk(0, 2'b00, 0, 32'hBFC00011, 32'h0,        32'h1234F056, 0,  32'h000000F0, 0, 4'h2, 32'h0);
    tbl[4]  = mk(0, 2'b01, 1, 32'hBFC00002, 32'h0,        32'h8001FFFF, 3,  32'hFFFF8001, 0, 4'hC, 32'h0);
    tbl[5]  = mk(0, 2'b10, 0, 32'hBFC00006, 32'h0,        32'h11111111, 0,  32'h0,        1, 4'h0, 32'h0);
    tbl[6]  = mk(1, 2'b01, 0, 32'h00000101, 32'h12345678, 32'h0,        0,  32'h0,        1, 4'h0, 32'h0);
    tbl[7]  = mk(1, 2'b01, 0, 32'h00000100, 32'h1234ABCD, 32'h0,        1,  32'h0,        0, 4'h3, 32'hABCDABCD);
    tbl[8]  = mk(0, 2'b01, 0, 32'h00000002, 32'h0,        32'h8001FFFF, 0,  32'h00008001, 0, 4'hC, 32'h0);
    tbl[9]  = mk(0, 2'b11, 1, 32'h00000020, 32'h0,        32'hCAFEF00D, 2,  32'hCAFEF00D, 0, 4'hF, 32'h0);
    tbl[10] = mk(0, 2'b00, 0, 32'h00000003, 32'h0,        32'h80FFFFFF, 0,  32'h00000080, 0, 4'h8, 32'h0);
    tbl[11] = mk(0, 2'b00, 1, 32'h00000003, 32'h0,        32'h80FFFFFF, 0,  32'hFFFFFF80, 0, 4'h8, 32'h0);
    tbl[12] = mk(0, 2'b10, 0, 32'h00000040, 32'h0,        32'h12345678, 10, 32'h12345678, 0, 4'hF, 32'h0);
    tbl[13] = mk(1, 2'b01, 0, 32'h00000042, 32'h0000BEEF, 32'h0,        9,  32'h0,        0, 4'hC, 32'hBEEFBEEF);
    tbl[14] = mk(1, 2'b00, 0, 32'h00000000, 32'h000000FF, 32'h0,        7,  32'h0,        0, 4'h1, 32'hFFFFFFFF);
    tbl[15] = mk(0, 2'b00, 1, 32'h00000001, 32'h0,        32'h00007F00, 8,  32'h0000007F, 0, 4'h2, 32'h0);

    reset = 1'b1;
    drive_req(1'b0, tbl[0]);
    if_a.waitrequest = 1'b0; if_b.waitrequest = 1'b0;
    if_a.readdata = 32'h0;   if_b.readdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.req_ready",  32'(if_a.req_ready),  32'd1);
    check("reset.read",       32'(if_a.read),       32'd0);
    check("reset.write",      32'(if_a.write),      32'd0);
    check("reset.resp_valid", 32'(if_a.resp_valid), 32'd0);
    check("reset.resp_err",   32'(if_a.resp_err),   32'd0);
    check("reset.resp_rdata", if_a.resp_rdata,      32'h0);
    check("reset.address",    if_a.address,         32'h0);
    check("reset.writedata",  if_a.writedata,       32'h0);
    check("reset.byteenable", 32'(if_a.byteenable), 32'h0);
    check("reset.b_ready",    32'(if_b.req_ready),  32'd1);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) run_txn(i, tbl[i], -1);

    // Reset while the read is stalled on the bus: strobe must drop at the edge.
    run_txn(16, mk(0, 2'b10, 0, 32'h00000080, 32'h0, 32'h0, 20, 32'h0, 0, 4'hF, 32'h0), 4);
    check("midrst.pre_read_a", 32'(if_a.read), 32'd1);
    check("midrst.pre_read_b", 32'(if_b.read), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst.read_a",       32'(if_a.read),       32'd0);
    check("midrst.read_b",       32'(if_b.read),       32'd0);
    check("midrst.req_ready_a",  32'(if_a.req_ready),  32'd1);
    check("midrst.req_ready_b",  32'(if_b.req_ready),  32'd1);
    check("midrst.resp_valid_b", 32'(if_b.resp_valid), 32'd0);
    reset = 1'b0;
    drive_req(1'b0, tbl[0]);
    if_a.waitrequest = 1'b0; if_b.waitrequest = 1'b0;
    @(posedge clk);
    #1;
    run_txn(17, tbl[2], -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
